tag_lookup_ctrl: RTL and testbench

TAG_LOOKUP_CTRL -- requirements
Module: tag_lookup_ctrl

---
 rtl/tag_lookup_ctrl_pkg.sv | 20 ++
 rtl/tag_lookup_ctrl_ram.sv | 28 ++
 rtl/tag_lookup_ctrl.sv | 141 ++++++++++++++
 tb/tb_tag_lookup_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tag_lookup_ctrl_pkg.sv
// Shared widths, FSM encoding and counter helper for the tag lookup controller, its tag RAM and bench.
package tag_lookup_ctrl_pkg;

    localparam int AWIDTH = 3;
    localparam int DWIDTH = 14;
    localparam int TAG_W  = DWIDTH - 1;
    localparam int CNT_W  = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOOKUP = 2'd1,
        ST_FILL   = 2'd2,
        ST_FLUSH  = 2'd3
    } state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/tag_lookup_ctrl_ram.sv
// Single-port tag RAM with one-cycle registered read; not reset, contents survive reset.
// Latency: dout reflects the address of the previous cycle (read-before-write); no backpressure.
module tag_lookup_ctrl_ram
    import tag_lookup_ctrl_pkg::*;
#(
    parameter int AW = AWIDTH,
    parameter int DW = DWIDTH
) (
    input  logic          i_clock,
    input  logic [AW-1:0] i_addr,
    input  logic [DW-1:0] i_din,
    input  logic          i_we,
    output logic [DW-1:0] o_dout
);

    logic [DW-1:0] r_mem [0:(1<<AW)-1];
    logic [DW-1:0] r_dout;

    always_ff @(posedge i_clock) begin
        if (i_we) begin
            r_mem[i_addr] <= i_din;
        end
        r_dout <= r_mem[i_addr];
    end

    assign o_dout = r_dout;

endmodule

// File: rtl/tag_lookup_ctrl.sv
// Tag lookup/fill/flush controller driving an external one-cycle-read tag RAM.
// Latency: response 2 cycles after accept; req_ready low outside IDLE (2/3-cycle request spacing).
module tag_lookup_ctrl #(
    parameter int AWIDTH = tag_lookup_ctrl_pkg::AWIDTH,
    parameter int DWIDTH = tag_lookup_ctrl_pkg::DWIDTH
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [AWIDTH+DWIDTH-2:0] req_addr,
    input  logic                     req_fill,
    input  logic                     flush,
    output logic                     resp_valid,
    output logic                     resp_hit,
    output logic [AWIDTH-1:0]        resp_index,
    output logic                     flush_done,
    output logic [AWIDTH-1:0]        ram_addr,
    output logic [DWIDTH-1:0]        ram_din,
    output logic                     ram_we,
    input  logic [DWIDTH-1:0]        ram_dout,
    output logic [15:0]              hit_count,
    output logic [15:0]              miss_count
);

    localparam int TW = DWIDTH - 1;

    tag_lookup_ctrl_pkg::state_t r_state;
    logic [AWIDTH-1:0] r_index;
    logic [TW-1:0]     r_tag;
    logic              r_fill;
    logic              r_resp_valid;
    logic              r_resp_hit;
    logic [AWIDTH-1:0] r_resp_index;
    logic              r_flush_done;
    logic [AWIDTH-1:0] r_flush_cnt;
    logic [15:0]       r_hit_count;
    logic [15:0]       r_miss_count;

    logic [AWIDTH-1:0] w_req_index;
    logic [TW-1:0]     w_req_tag;
    logic              w_accept;
    logic              w_lookup;
    logic              w_hit;
    logic [15:0]       w_hit_next;
    logic [15:0]       w_miss_next;

    assign w_req_index = req_addr[AWIDTH-1:0];
    assign w_req_tag   = req_addr[AWIDTH+DWIDTH-2:AWIDTH];
    assign req_ready   = (r_state == tag_lookup_ctrl_pkg::ST_IDLE) & ~flush & ~reset;
    assign w_accept    = req_valid & req_ready;
    assign w_lookup    = (r_state == tag_lookup_ctrl_pkg::ST_LOOKUP);
    assign w_hit       = ram_dout[DWIDTH-1] & (ram_dout[TW-1:0] == r_tag);

    // Counters commit on the same edge that registers the response, so they move with resp_valid.
    assign w_hit_next  = (w_lookup & w_hit)  ? tag_lookup_ctrl_pkg::sat_inc(r_hit_count)  : r_hit_count;
    assign w_miss_next = (w_lookup & ~w_hit) ? tag_lookup_ctrl_pkg::sat_inc(r_miss_count) : r_miss_count;

    always_comb begin
        ram_addr = w_req_index;
        ram_din  = '0;
        ram_we   = 1'b0;
        case (r_state)
            tag_lookup_ctrl_pkg::ST_LOOKUP: begin
                ram_addr = r_index;
            end
            tag_lookup_ctrl_pkg::ST_FILL: begin
                ram_addr = r_index;
                ram_din  = {1'b1, r_tag};
                ram_we   = ~reset;
            end
            tag_lookup_ctrl_pkg::ST_FLUSH: begin
                ram_addr = r_flush_cnt;
                ram_we   = ~reset;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= tag_lookup_ctrl_pkg::ST_IDLE;
            r_index      <= '0;
            r_tag        <= '0;
            r_fill       <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_hit   <= 1'b0;
            r_resp_index <= '0;
            r_flush_done <= 1'b0;
            r_flush_cnt  <= '0;
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else begin
            r_resp_valid <= w_lookup;
            r_flush_done <= 1'b0;
            r_hit_count  <= w_hit_next;
            r_miss_count <= w_miss_next;
            case (r_state)
                tag_lookup_ctrl_pkg::ST_IDLE: begin
                    if (flush) begin
                        r_state     <= tag_lookup_ctrl_pkg::ST_FLUSH;
                        r_flush_cnt <= '0;
                    end else if (w_accept) begin
                        r_index <= w_req_index;
                        r_tag   <= w_req_tag;
                        r_fill  <= req_fill;
                        r_state <= tag_lookup_ctrl_pkg::ST_LOOKUP;
                    end
                end
                tag_lookup_ctrl_pkg::ST_LOOKUP: begin
                    r_resp_hit   <= w_hit;
                    r_resp_index <= r_index;
                    r_state      <= (~w_hit & r_fill) ? tag_lookup_ctrl_pkg::ST_FILL
                                                      : tag_lookup_ctrl_pkg::ST_IDLE;
                end
                tag_lookup_ctrl_pkg::ST_FILL: begin
                    r_state <= tag_lookup_ctrl_pkg::ST_IDLE;
                end
                tag_lookup_ctrl_pkg::ST_FLUSH: begin
                    r_flush_cnt <= r_flush_cnt + 1'b1;
                    if (&r_flush_cnt) begin
                        r_state      <= tag_lookup_ctrl_pkg::ST_IDLE;
                        r_flush_done <= 1'b1;
                    end
                end
                default: begin
                    r_state <= tag_lookup_ctrl_pkg::ST_IDLE;
                end
            endcase
        end
    end

    assign resp_valid = r_resp_valid;
    assign resp_hit   = r_resp_hit;
    assign resp_index = r_resp_index;
    assign flush_done = r_flush_done;
    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;

endmodule

// File: tb/tb_tag_lookup_ctrl.sv
// Directed bench for tag_lookup_ctrl with its tag RAM; bench can take over the RAM port to preload.
module tb_tag_lookup_ctrl;
    import tag_lookup_ctrl_pkg::*;

    logic                     clock = 1'b0;
    logic                     reset;
    logic                     req_valid;
    logic                     req_ready;
    logic [AWIDTH+DWIDTH-2:0] req_addr;
    logic                     req_fill;
    logic                     flush;
    logic                     resp_valid;
    logic                     resp_hit;
    logic [AWIDTH-1:0]        resp_index;
    logic                     flush_done;
    logic [AWIDTH-1:0]        ram_addr;
    logic [DWIDTH-1:0]        ram_din;
    logic                     ram_we;
    logic [DWIDTH-1:0]        ram_dout;
    logic [15:0]              hit_count;
    logic [15:0]              miss_count;

    logic                     tb_load;
    logic                     tb_we;
    logic [AWIDTH-1:0]        tb_addr;
    logic [DWIDTH-1:0]        tb_din;
    logic [AWIDTH-1:0]        w_ram_addr;
    logic [DWIDTH-1:0]        w_ram_din;
    logic                     w_ram_we;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int n_resp = 0;
    int acc_q[$];

    always #5 clock = ~clock;

    assign w_ram_addr = tb_load ? tb_addr : ram_addr;
    assign w_ram_din  = tb_load ? tb_din  : ram_din;
    assign w_ram_we   = tb_load ? tb_we   : ram_we;

    tag_lookup_ctrl dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_fill   (req_fill),
        .flush      (flush),
        .resp_valid (resp_valid),
        .resp_hit   (resp_hit),
        .resp_index (resp_index),
        .flush_done (flush_done),
        .ram_addr   (ram_addr),
        .ram_din    (ram_din),
        .ram_we     (ram_we),
        .ram_dout   (ram_dout),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    tag_lookup_ctrl_ram u_ram (
        .i_clock (clock),
        .i_addr  (w_ram_addr),
        .i_din   (w_ram_din),
        .i_we    (w_ram_we),
        .o_dout  (ram_dout)
    );

    // Pre-edge values: an accept or response seen here belongs to the cycle just ending.
    always @(posedge clock) begin
        cyc++;
        if (req_valid && req_ready) acc_q.push_back(cyc);
        if (resp_valid) n_resp++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic ram_load(input logic [AWIDTH-1:0] idx, input logic [DWIDTH-1:0] data);
        @(negedge clock);
        tb_load = 1'b1;
        tb_we   = 1'b1;
        tb_addr = idx;
        tb_din  = data;
        @(negedge clock);
        tb_load = 1'b0;
        tb_we   = 1'b0;
    endtask

    // Issues one request and returns at the negedge of cycle N+2 with the response on the outputs.
    task automatic do_req(input string tag, input logic [15:0] addr, input logic fill,
                          input logic exp_hit, input logic [AWIDTH-1:0] exp_idx,
                          input logic exp_we, input logic [DWIDTH-1:0] exp_din);
        @(negedge clock);
        req_addr  = addr;
        req_fill  = fill;
        req_valid = 1'b1;
        #1 chk({tag, "_ready"}, req_ready, 1);
        @(negedge clock);
        req_valid = 1'b0;
        chk({tag, "_no_early_resp"}, resp_valid, 0);
        @(negedge clock);
        chk({tag, "_resp_valid"}, resp_valid, 1);
        chk({tag, "_resp_hit"}, resp_hit, exp_hit);
        chk({tag, "_resp_index"}, resp_index, exp_idx);
        chk({tag, "_ram_we"}, ram_we, exp_we);
        if (exp_we) begin
            chk({tag, "_fill_addr"}, ram_addr, exp_idx);
            chk({tag, "_fill_din"}, ram_din, exp_din);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] seq [6];
        int          exp_gap [5];
        int          base;
        int          resp_base;
        int          idx;
        bit          pend;

        reset     = 1'b1;
        req_valid = 1'b0;
        req_addr  = '0;
        req_fill  = 1'b0;
        flush     = 1'b0;
        tb_load   = 1'b0;
        tb_we     = 1'b0;
        tb_addr   = '0;
        tb_din    = '0;

        repeat (2) @(negedge clock);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_ram_we", ram_we, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_hit", resp_hit, 0);
        chk("rst_resp_index", resp_index, 0);
        chk("rst_flush_done", flush_done, 0);
        chk("rst_hit_count", hit_count, 0);
        chk("rst_miss_count", miss_count, 0);
        reset = 1'b0;

        // Flush wins over a simultaneous request; 8 zero writes, done pulse, then the request goes in.
        @(negedge clock);
        flush     = 1'b1;
        req_valid = 1'b1;
        req_addr  = 16'h1235;
        req_fill  = 1'b0;
        #1 chk("flush_blocks_ready", req_ready, 0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clock);
            flush = 1'b0;
            chk("flush_we", ram_we, 1);
            chk("flush_addr", ram_addr, k);
            chk("flush_din", ram_din, 0);
            chk("flush_done_early", flush_done, 0);
        end
        @(negedge clock);
        chk("flush_done_pulse", flush_done, 1);
        chk("post_flush_ready", req_ready, 1);
        chk("post_flush_we", ram_we, 0);
        @(negedge clock);
        req_valid = 1'b0;
        chk("flush_done_one_cycle", flush_done, 0);
        chk("post_flush_no_early_resp", resp_valid, 0);
        @(negedge clock);
        chk("post_flush_resp_valid", resp_valid, 1);
        chk("post_flush_resp_hit", resp_hit, 0);
        chk("post_flush_resp_index", resp_index, 5);
        for (int i = 0; i < 8; i++) chk("flush_ram_zero", u_ram.r_mem[i], 0);

        // Hit on a preloaded entry: idx5 holds {1,0x246}.
        ram_load(3'd5, 14'h2246);
        do_req("hit5", 16'h1235, 1'b0, 1'b1, 3'd5, 1'b0, 14'h0);
        @(negedge clock);
        chk("hit5_hit_count", hit_count, 1);
        chk("hit5_miss_count", miss_count, 1);

        // Miss with fill at idx2, then the same address hits.
        do_req("fill2", 16'h0F0A, 1'b1, 1'b0, 3'd2, 1'b1, 14'h21E1);
        @(negedge clock);
        chk("fill2_ram_word", u_ram.r_mem[2], 14'h21E1);
        do_req("rehit2", 16'h0F0A, 1'b1, 1'b1, 3'd2, 1'b0, 14'h0);

        // Held req_valid, alternating hit and filled miss.
        seq[0] = 16'h1235; seq[1] = 16'h000B; seq[2] = 16'h1235;
        seq[3] = 16'h0013; seq[4] = 16'h1235; seq[5] = 16'h001B;
        exp_gap[0] = 2; exp_gap[1] = 3; exp_gap[2] = 2; exp_gap[3] = 3; exp_gap[4] = 2;
        @(negedge clock);
        base      = acc_q.size();
        resp_base = n_resp;
        idx       = 0;
        pend      = 1'b0;
        req_fill  = 1'b1;
        req_addr  = seq[0];
        req_valid = 1'b1;
        for (int c = 0; c < 60 && idx < 6; c++) begin
            if (c != 0) @(negedge clock);
            if (pend) begin
                pend = 1'b0;
                idx++;
                if (idx == 6) req_valid = 1'b0;
                else req_addr = seq[idx];
            end
            #1;
            if (req_valid && req_ready) pend = 1'b1;
        end
        chk("stream_all_issued", idx, 6);
        repeat (4) @(negedge clock);
        chk("stream_accepts", acc_q.size() - base, 6);
        chk("stream_responses", n_resp - resp_base, 6);
        if (acc_q.size() >= base + 6) begin
            for (int j = 0; j < 5; j++)
                chk("stream_gap", acc_q[base+j+1] - acc_q[base+j], exp_gap[j]);
        end
        chk("stream_hit_count", hit_count, 5);
        chk("stream_miss_count", miss_count, 5);

        // Reset landing in the FILL cycle must suppress the write.
        do_req("rstfill", 16'h02AE, 1'b1, 1'b0, 3'd6, 1'b1, 14'h2055);
        reset = 1'b1;
        #1 chk("rstfill_we_blocked", ram_we, 0);
        @(negedge clock);
        chk("rstfill_resp_valid", resp_valid, 0);
        chk("rstfill_resp_hit", resp_hit, 0);
        chk("rstfill_resp_index", resp_index, 0);
        chk("rstfill_flush_done", flush_done, 0);
        chk("rstfill_hit_count", hit_count, 0);
        chk("rstfill_miss_count", miss_count, 0);
        chk("rstfill_ram_we", ram_we, 0);
        chk("rstfill_ram_unchanged", u_ram.r_mem[6], 0);
        chk("rstfill_ram_kept", u_ram.r_mem[5], 14'h2246);
        reset = 1'b0;

        // Miss counter saturation.
        @(negedge clock);
        force dut.r_miss_count = 16'hFFFF;
        repeat (2) @(negedge clock);
        release dut.r_miss_count;
        #1 chk("sat_preload", miss_count, 16'hFFFF);
        do_req("sat_miss", 16'h03B9, 1'b0, 1'b0, 3'd1, 1'b0, 14'h0);
        @(negedge clock);
        chk("sat_miss_count", miss_count, 16'hFFFF);
        chk("sat_hit_count", hit_count, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
